envelope_sequencer: RTL and testbench

Per-voice ADSR envelope controller that sequences the synth amplitude through attack, decay, sustain and release. It consumes the 0–4 sustain-time code produced by the sustain pot decoder and a note trigger, and produces an 8-bit amplitude that scales the voice output. Sits between the user-control decoders and the voice amplitude multiplier, one instance per voice, all on the board clock.

---
 rtl/envelope_sequencer_pkg.sv | 16 +
 rtl/envelope_sequencer_tick_gen.sv | 33 +++
 rtl/envelope_sequencer.sv | 156 +++++++++++++++
 tb/tb_envelope_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_sequencer_pkg.sv
// Shared definitions for the envelope sequencer and its neighbours:
// state encodings, amplitude width and the sustain-code ceiling.
package envelope_sequencer_pkg;

    localparam int AMP_W            = 8;
    localparam int SUSTAIN_CODE_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

endpackage

// File: rtl/envelope_sequencer_tick_gen.sv
// Free-running prescaler: tick is high for one clk every TICK_DIV clks.
// Ports: clk, reset (sync, active-high), tick (one-cycle strobe).
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/envelope_sequencer.sv
// Per-voice ADSR envelope: sequences an 8-bit amplitude through attack,
// decay, sustain and release, stepping once per prescaler tick.
// Ports: clk, reset (sync, active-high), note_trig (start/retrigger pulse),
// sustainTime (0-4 code), amplitude, env_state, busy, done (end pulse).
module envelope_sequencer
    import envelope_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned ATK_STEP  = 8,
    parameter int unsigned DEC_STEP  = 4,
    parameter int unsigned SUS_LEVEL = 160,
    parameter int unsigned SUS_UNIT  = 250,
    parameter int unsigned REL_STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             note_trig,
    input  logic [3:0]       sustainTime,
    output logic [AMP_W-1:0] amplitude,
    output logic [2:0]       env_state,
    output logic             busy,
    output logic             done
);

    localparam int SUS_W = $clog2(SUSTAIN_CODE_MAX * SUS_UNIT + 1);
    localparam logic [AMP_W-1:0] SUS_AMP = AMP_W'(SUS_LEVEL);

    logic             tick;
    logic [2:0]       state_q, state_d;
    logic [AMP_W-1:0] amp_q, amp_d;
    logic [SUS_W-1:0] sus_q, sus_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       code_c;
    logic [SUS_W-1:0] sus_load;
    logic [AMP_W:0]   atk_sum;
    logic [AMP_W:0]   dec_diff;
    logic [AMP_W:0]   rel_diff;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Sustain length: code clamped to 1..SUSTAIN_CODE_MAX, in ticks.
    always_comb begin
        if (sustainTime > 4'(SUSTAIN_CODE_MAX)) begin
            code_c = 3'(SUSTAIN_CODE_MAX);
        end else if (sustainTime == 4'd0) begin
            code_c = 3'd1;
        end else begin
            code_c = sustainTime[2:0];
        end
        sus_load = SUS_W'(code_c) * SUS_W'(SUS_UNIT);
    end

    // One extra bit catches attack overflow and decay/release underflow.
    assign atk_sum  = {1'b0, amp_q} + (AMP_W+1)'(ATK_STEP);
    assign dec_diff = {1'b0, amp_q} - (AMP_W+1)'(DEC_STEP);
    assign rel_diff = {1'b0, amp_q} - (AMP_W+1)'(REL_STEP);

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        sus_d   = sus_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                amp_d = '0;
                if (note_trig) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE: begin
                if (note_trig) begin
                    // Retrigger resumes from the current level.
                    state_d = ST_ATTACK;
                    sus_d   = '0;
                end else if (tick) begin
                    case (state_q)
                        ST_ATTACK: begin
                            if (atk_sum >= (AMP_W+1)'(255)) begin
                                amp_d   = 8'hFF;
                                state_d = ST_DECAY;
                            end else begin
                                amp_d = atk_sum[AMP_W-1:0];
                            end
                        end
                        ST_DECAY: begin
                            if (dec_diff[AMP_W] ||
                                dec_diff[AMP_W-1:0] <= SUS_AMP) begin
                                amp_d   = SUS_AMP;
                                state_d = ST_SUSTAIN;
                                sus_d   = sus_load;
                            end else begin
                                amp_d = dec_diff[AMP_W-1:0];
                            end
                        end
                        ST_SUSTAIN: begin
                            if (sus_q <= SUS_W'(1)) begin
                                sus_d   = '0;
                                state_d = ST_RELEASE;
                            end else begin
                                sus_d = sus_q - SUS_W'(1);
                            end
                        end
                        ST_RELEASE: begin
                            if (rel_diff[AMP_W] ||
                                rel_diff[AMP_W-1:0] == '0) begin
                                amp_d   = '0;
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                amp_d = rel_diff[AMP_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                // Unused encodings fall back to a silent IDLE.
                state_d = ST_IDLE;
                amp_d   = '0;
                sus_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            amp_q   <= '0;
            sus_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            sus_q   <= sus_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign amplitude = amp_q;
    assign env_state = state_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Scoreboard bench for envelope_sequencer: expected output events are
// queued by stimulus and matched by a monitor on every output change.
module tb_envelope_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       note_trig = 1'b0;
    logic [3:0] sustainTime = 4'd0;
    logic [7:0] amplitude;
    logic [2:0] env_state;
    logic       busy;
    logic       done;

    envelope_sequencer #(
        .TICK_DIV  (4),
        .ATK_STEP  (64),
        .DEC_STEP  (32),
        .SUS_LEVEL (160),
        .SUS_UNIT  (2),
        .REL_STEP  (40)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .note_trig   (note_trig),
        .sustainTime (sustainTime),
        .amplitude   (amplitude),
        .env_state   (env_state),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int amp;
        int st;
        int dn;
        int dt;
    } ev_t;

    ev_t exp_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int presc_m = 0;
    int tick_ctr = 0;
    int last_tick = 0;
    bit mon_en = 1'b0;
    logic [7:0] p_amp;
    logic [2:0] p_st;
    logic       p_dn;

    // Reference prescaler: counts envelope ticks independently of the DUT.
    always @(posedge clk) begin
        if (reset) begin
            presc_m = 0;
        end else if (presc_m == 3) begin
            presc_m = 0;
            tick_ctr++;
        end else begin
            presc_m++;
        end
    end

    always @(negedge clk) begin
        if (mon_en && (amplitude !== p_amp || env_state !== p_st ||
                       done !== p_dn)) begin
            int dt;
            ev_t e;
            dt = tick_ctr - last_tick;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event amp=%0d st=%0d done=%0d",
                         amplitude, env_state, done);
            end else begin
                e = exp_q.pop_front();
                if (amplitude !== 8'(e.amp) || env_state !== 3'(e.st) ||
                    done !== 1'(e.dn) || busy !== (e.st != 0) ||
                    (e.dt >= 0 && dt != e.dt)) begin
                    n_fail++;
                    $display({"FAIL event got amp=%0d st=%0d done=%0d ",
                              "busy=%0d ticks=%0d, want amp=%0d st=%0d ",
                              "done=%0d busy=%0d ticks=%0d"},
                             amplitude, env_state, done, busy, dt,
                             e.amp, e.st, e.dn, (e.st != 0), e.dt);
                end
            end
            last_tick = tick_ctr;
            p_amp = amplitude;
            p_st  = env_state;
            p_dn  = done;
        end
    end

    task automatic push(input int a, input int s, input int d, input int t);
        ev_t e;
        e.amp = a;
        e.st  = s;
        e.dn  = d;
        e.dt  = t;
        exp_q.push_back(e);
    endtask

    task automatic push_rise();
        push(0, 1, 0, -1);
        push(64, 1, 0, 1);
        push(128, 1, 0, 1);
        push(192, 1, 0, 1);
        push(255, 2, 0, 1);
    endtask

    task automatic push_decay();
        push(223, 2, 0, 1);
        push(191, 2, 0, 1);
        push(160, 3, 0, 1);
    endtask

    task automatic push_release(input int sus_ticks);
        push(160, 4, 0, sus_ticks);
        push(120, 4, 0, 1);
        push(80, 4, 0, 1);
        push(40, 4, 0, 1);
        push(0, 0, 1, 1);
        push(0, 0, 0, -1);
    endtask

    task automatic push_full(input int sus_ticks);
        push_rise();
        push_decay();
        push_release(sus_ticks);
    endtask

    task automatic pulse_trig();
        note_trig = 1'b1;
        @(negedge clk);
        note_trig = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic wait_sa(input int a, input int s);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (amplitude == 8'(a) && env_state == 3'(s)) begin
                found = 1'b1;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_timeout amp=%0d st=%0d want amp=%0d st=%0d",
                     amplitude, env_state, a, s);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s drain_timeout left=%0d want 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_amp", int'(amplitude), 0);
        check("reset_state", int'(env_state), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        p_amp = amplitude;
        p_st  = env_state;
        p_dn  = done;
        last_tick = tick_ctr;
        mon_en = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full envelope, code 3 -> 6 sustain ticks.
        sustainTime = 4'd3;
        push_full(6);
        pulse_trig();
        drain("full_code3");

        // Code 0 clamps up to 1, code 9 clamps down to 4.
        sustainTime = 4'd0;
        push_full(2);
        pulse_trig();
        drain("code0");
        sustainTime = 4'd9;
        push_full(8);
        pulse_trig();
        drain("code9");

        // Retrigger in RELEASE at 80.
        sustainTime = 4'd1;
        push_rise();
        push_decay();
        push(160, 4, 0, 2);
        push(120, 4, 0, 1);
        push(80, 4, 0, 1);
        push(80, 1, 0, -1);
        push(144, 1, 0, 1);
        push(208, 1, 0, 1);
        push(255, 2, 0, 1);
        push_decay();
        push_release(2);
        pulse_trig();
        wait_sa(80, 4);
        pulse_trig();
        drain("retrig_release");

        // Trigger coincident with a tick during SUSTAIN.
        sustainTime = 4'd1;
        push_rise();
        push_decay();
        push(160, 1, 0, 1);
        push(224, 1, 0, 1);
        push(255, 2, 0, 1);
        push_decay();
        push_release(2);
        pulse_trig();
        wait_sa(160, 3);
        for (int k = 0; k < 4 && presc_m != 3; k++) begin
            @(negedge clk);
        end
        pulse_trig();
        drain("trig_on_tick");

        // Reset mid-DECAY, then a clean envelope.
        sustainTime = 4'd1;
        push_rise();
        push(223, 2, 0, 1);
        push(0, 0, 0, -1);
        pulse_trig();
        wait_sa(223, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drain("reset_mid_decay");
        push_full(2);
        pulse_trig();
        drain("after_reset");

        // Code change during SUSTAIN is ignored.
        sustainTime = 4'd1;
        push_full(2);
        pulse_trig();
        wait_sa(160, 3);
        sustainTime = 4'd4;
        drain("code_change_sus");

        check("final_busy", int'(busy), 0);
        check("final_state", int'(env_state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
